// File: rtl/comparator_search.sv
// Binary search of a 4-bit secret through an external registered comparator.
// Each probe is one PROBE cycle followed by one CHECK cycle.
module comparator_search (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       start,
    input  logic       A_lt_B,
    input  logic       A_gt_B,
    input  logic       A_eq_B,
    output logic [3:0] guess,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic       err,
    output logic [3:0] result,
    output logic [2:0] probes
);

    typedef enum logic [1:0] {IDLE, PROBE, CHECK} state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_lo, r_hi, r_guess, r_result;
    logic [3:0] w_lo_nxt, w_hi_nxt, w_guess_nxt, w_result_nxt;
    logic [2:0] r_probes, w_probes_nxt;
    logic       r_busy, r_done, r_found, r_err;
    logic       w_busy_nxt, w_done_nxt, w_found_nxt, w_err_nxt;
    logic       w_fail;

    // Midpoints use a 5-bit sum so guess+1+hi cannot overflow before the shift.
    logic [4:0] w_sum_up, w_sum_dn;
    logic [3:0] w_mid_up, w_mid_dn;

    assign w_sum_up = {1'b0, r_guess} + 5'd1 + {1'b0, r_hi};
    assign w_sum_dn = {1'b0, r_lo} + {1'b0, r_guess} - 5'd1;
    assign w_mid_up = 4'(w_sum_up >> 1);
    assign w_mid_dn = 4'(w_sum_dn >> 1);

    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_state  <= IDLE;
            r_lo     <= 4'd0;
            r_hi     <= 4'd15;
            r_guess  <= 4'd0;
            r_result <= 4'd0;
            r_probes <= 3'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values of the others.
            r_state  <= w_state_nxt;
            r_lo     <= w_lo_nxt;
            r_hi     <= w_hi_nxt;
            r_guess  <= w_guess_nxt;
            r_result <= w_result_nxt;
            r_probes <= w_probes_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_found  <= w_found_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt  = r_state;
        w_lo_nxt     = r_lo;
        w_hi_nxt     = r_hi;
        w_guess_nxt  = r_guess;
        w_result_nxt = r_result;
        w_probes_nxt = r_probes;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_found_nxt  = r_found;
        w_err_nxt    = r_err;
        w_fail       = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_lo_nxt     = 4'd0;
                    w_hi_nxt     = 4'd15;
                    w_guess_nxt  = 4'd7;
                    w_probes_nxt = 3'd0;
                    w_found_nxt  = 1'b0;
                    w_err_nxt    = 1'b0;
                    w_result_nxt = 4'd0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = PROBE;
                end
            end
            PROBE: w_state_nxt = CHECK;
            CHECK: begin
                w_probes_nxt = r_probes + 3'd1;
                case ({A_lt_B, A_gt_B, A_eq_B})
                    3'b001: begin
                        w_found_nxt  = 1'b1;
                        w_result_nxt = r_guess;
                        w_done_nxt   = 1'b1;
                        w_busy_nxt   = 1'b0;
                        w_state_nxt  = IDLE;
                    end
                    3'b100: begin
                        if (r_guess == r_hi) begin
                            w_fail = 1'b1;
                        end else begin
                            w_lo_nxt    = r_guess + 4'd1;
                            w_guess_nxt = w_mid_up;
                            w_state_nxt = PROBE;
                        end
                    end
                    3'b010: begin
                        if (r_guess == r_lo) begin
                            w_fail = 1'b1;
                        end else begin
                            w_hi_nxt    = r_guess - 4'd1;
                            w_guess_nxt = w_mid_dn;
                            w_state_nxt = PROBE;
                        end
                    end
                    default: w_fail = 1'b1;
                endcase
                // Inconsistent flags and an exhausted range end the search the same way.
                if (w_fail) begin
                    w_err_nxt    = 1'b1;
                    w_found_nxt  = 1'b0;
                    w_result_nxt = r_guess;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign guess  = r_guess;
    assign busy   = r_busy;
    assign done   = r_done;
    assign found  = r_found;
    assign err    = r_err;
    assign result = r_result;
    assign probes = r_probes;

endmodule
